// File: rtl/id_exe_reg_pkg.sv
// Shared definitions for the ID/EXE pipeline register: execute command encodings,
// status flag positions and the registered payload layout.
package id_exe_reg_pkg;

  localparam int unsigned PC_W     = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned CMD_W    = 4;
  localparam int unsigned REG_W    = 4;
  localparam int unsigned SHIFT_W  = 12;
  localparam int unsigned IMM24_W  = 24;
  localparam int unsigned STATUS_W = 4;

  // Flag positions inside the {N,Z,C,V} status word
  localparam int unsigned STATUS_N = 3;
  localparam int unsigned STATUS_Z = 2;
  localparam int unsigned STATUS_C = 1;
  localparam int unsigned STATUS_V = 0;

  typedef enum logic [CMD_W-1:0] {
    EXE_NOP = 4'b0000,
    EXE_MOV = 4'b0001,
    EXE_ADD = 4'b0010,
    EXE_ADC = 4'b0011,
    EXE_SUB = 4'b0100,
    EXE_SBC = 4'b0101,
    EXE_AND = 4'b0110,
    EXE_ORR = 4'b0111,
    EXE_EOR = 4'b1000,
    EXE_MVN = 4'b1001
  } exe_cmd_e;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [DATA_W-1:0]  val_rn;
    logic [DATA_W-1:0]  val_rm;
    logic [CMD_W-1:0]   exe_cmd;
    logic               wb_en;
    logic               mem_r_en;
    logic               mem_w_en;
    logic               b;
    logic               s;
    logic               valid;
    logic               imm;
    logic [SHIFT_W-1:0] shift_operand;
    logic [IMM24_W-1:0] signed_imm_24;
    logic [REG_W-1:0]   dest;
    logic [REG_W-1:0]   src1;
    logic [REG_W-1:0]   src2;
  } id_exe_t;

endpackage

// File: rtl/id_exe_reg_status_reg.sv
// Status flag register with load enable; cleared asynchronously on reset.
module status_reg
  import id_exe_reg_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ld,
  input  logic [STATUS_W-1:0] d,
  output logic [STATUS_W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (ld) begin
      q <= d;
    end
  end

endmodule

// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register with flush/freeze control, bubble propagation and
// the processor status flags written back from the execute stage.
module id_exe_reg
  import id_exe_reg_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                freeze,
  input  logic [31:0]         pc_in,
  input  logic [31:0]         val_rn_in,
  input  logic [31:0]         val_rm_in,
  input  logic [3:0]          exe_cmd_in,
  input  logic                wb_en_in,
  input  logic                mem_r_en_in,
  input  logic                mem_w_en_in,
  input  logic                b_in,
  input  logic                s_in,
  input  logic                valid_in,
  input  logic                imm_in,
  input  logic [11:0]         shift_operand_in,
  input  logic [23:0]         signed_imm_24_in,
  input  logic [3:0]          dest_in,
  input  logic [3:0]          src1_in,
  input  logic [3:0]          src2_in,
  input  logic [3:0]          status_in,
  output logic [31:0]         pc_out,
  output logic [31:0]         val_rn_out,
  output logic [31:0]         val_rm_out,
  output logic [3:0]          exe_cmd_out,
  output logic                wb_en_out,
  output logic                mem_r_en_out,
  output logic                mem_w_en_out,
  output logic                b_out,
  output logic                s_out,
  output logic                valid_out,
  output logic                imm_out,
  output logic [11:0]         shift_operand_out,
  output logic [23:0]         signed_imm_24_out,
  output logic [3:0]          dest_out,
  output logic [3:0]          src1_out,
  output logic [3:0]          src2_out,
  output logic [3:0]          status_out,
  output logic                carry_out
);

  id_exe_t             in_pkt;
  id_exe_t             pipe_d;
  id_exe_t             pipe_q;
  logic                status_ld_c;
  logic [STATUS_W-1:0] status_q;

  // Next pipeline contents: flush beats freeze; invalid slots carry no side effects
  always_comb begin
    in_pkt               = '0;
    in_pkt.pc            = pc_in;
    in_pkt.val_rn        = val_rn_in;
    in_pkt.val_rm        = val_rm_in;
    in_pkt.exe_cmd       = exe_cmd_in;
    in_pkt.wb_en         = wb_en_in;
    in_pkt.mem_r_en      = mem_r_en_in;
    in_pkt.mem_w_en      = mem_w_en_in;
    in_pkt.b             = b_in;
    in_pkt.s             = s_in;
    in_pkt.valid         = valid_in;
    in_pkt.imm           = imm_in;
    in_pkt.shift_operand = shift_operand_in;
    in_pkt.signed_imm_24 = signed_imm_24_in;
    in_pkt.dest          = dest_in;
    in_pkt.src1          = src1_in;
    in_pkt.src2          = src2_in;
    if (!valid_in) begin
      in_pkt.wb_en    = 1'b0;
      in_pkt.mem_r_en = 1'b0;
      in_pkt.mem_w_en = 1'b0;
      in_pkt.b        = 1'b0;
      in_pkt.s        = 1'b0;
    end

    pipe_d = pipe_q;
    if (flush) begin
      pipe_d = '0;
    end else if (!freeze) begin
      pipe_d = in_pkt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign pc_out            = pipe_q.pc;
  assign val_rn_out        = pipe_q.val_rn;
  assign val_rm_out        = pipe_q.val_rm;
  assign exe_cmd_out       = pipe_q.exe_cmd;
  assign wb_en_out         = pipe_q.wb_en;
  assign mem_r_en_out      = pipe_q.mem_r_en;
  assign mem_w_en_out      = pipe_q.mem_w_en;
  assign b_out             = pipe_q.b;
  assign s_out             = pipe_q.s;
  assign valid_out         = pipe_q.valid;
  assign imm_out           = pipe_q.imm;
  assign shift_operand_out = pipe_q.shift_operand;
  assign signed_imm_24_out = pipe_q.signed_imm_24;
  assign dest_out          = pipe_q.dest;
  assign src1_out          = pipe_q.src1;
  assign src2_out          = pipe_q.src2;

  // The instruction sitting in execute commits its flags even when the incoming one is flushed
  assign status_ld_c = pipe_q.s & pipe_q.valid & ~freeze;

  status_reg u_status_reg (
    .clk   (clk),
    .rst_n (rst),
    .ld    (status_ld_c),
    .d     (status_in),
    .q     (status_q)
  );

  assign status_out = status_q;
  assign carry_out  = status_q[STATUS_C];

endmodule

// File: tb/tb_id_exe_reg.sv
// Randomized self-checking bench for id_exe_reg against a behavioural pipeline-register model.
module tb_id_exe_reg;
  import id_exe_reg_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rn;
    logic [31:0] rm;
    logic [3:0]  cmd;
    logic        wb;
    logic        mr;
    logic        mw;
    logic        b;
    logic        s;
    logic        valid;
    logic        imm;
    logic [11:0] shop;
    logic [23:0] simm;
    logic [3:0]  dest;
    logic [3:0]  src1;
    logic [3:0]  src2;
  } tb_fields_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0, freeze = 1'b0;
  logic [31:0] pc_in = '0, val_rn_in = '0, val_rm_in = '0;
  logic [3:0]  exe_cmd_in = '0;
  logic        wb_en_in = 1'b0, mem_r_en_in = 1'b0, mem_w_en_in = 1'b0, b_in = 1'b0, s_in = 1'b0;
  logic        valid_in = 1'b0, imm_in = 1'b0;
  logic [11:0] shift_operand_in = '0;
  logic [23:0] signed_imm_24_in = '0;
  logic [3:0]  dest_in = '0, src1_in = '0, src2_in = '0, status_in = '0;

  logic [31:0] pc_out, val_rn_out, val_rm_out;
  logic [3:0]  exe_cmd_out;
  logic        wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, valid_out, imm_out;
  logic [11:0] shift_operand_out;
  logic [23:0] signed_imm_24_out;
  logic [3:0]  dest_out, src1_out, src2_out, status_out;
  logic        carry_out;

  tb_fields_t  m_f;
  logic [3:0]  m_status;
  int          vectors = 0;
  int          miscompares = 0;

  id_exe_reg dut (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
    .pc_in(pc_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
    .exe_cmd_in(exe_cmd_in), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
    .mem_w_en_in(mem_w_en_in), .b_in(b_in), .s_in(s_in), .valid_in(valid_in),
    .imm_in(imm_in), .shift_operand_in(shift_operand_in),
    .signed_imm_24_in(signed_imm_24_in), .dest_in(dest_in), .src1_in(src1_in),
    .src2_in(src2_in), .status_in(status_in),
    .pc_out(pc_out), .val_rn_out(val_rn_out), .val_rm_out(val_rm_out),
    .exe_cmd_out(exe_cmd_out), .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
    .mem_w_en_out(mem_w_en_out), .b_out(b_out), .s_out(s_out), .valid_out(valid_out),
    .imm_out(imm_out), .shift_operand_out(shift_operand_out),
    .signed_imm_24_out(signed_imm_24_out), .dest_out(dest_out), .src1_out(src1_out),
    .src2_out(src2_out), .status_out(status_out), .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  function automatic tb_fields_t dut_fields();
    return '{pc_out, val_rn_out, val_rm_out, exe_cmd_out, wb_en_out, mem_r_en_out,
             mem_w_en_out, b_out, s_out, valid_out, imm_out, shift_operand_out,
             signed_imm_24_out, dest_out, src1_out, src2_out};
  endfunction

  function automatic tb_fields_t input_fields();
    return '{pc_in, val_rn_in, val_rm_in, exe_cmd_in, wb_en_in, mem_r_en_in,
             mem_w_en_in, b_in, s_in, valid_in, imm_in, shift_operand_in,
             signed_imm_24_in, dest_in, src1_in, src2_in};
  endfunction

  task automatic randomize_inputs();
    pc_in            = $urandom;
    val_rn_in        = $urandom;
    val_rm_in        = $urandom;
    exe_cmd_in       = 4'($urandom_range(0, 9));
    wb_en_in         = 1'($urandom);
    mem_r_en_in      = 1'($urandom);
    mem_w_en_in      = 1'($urandom);
    b_in             = 1'($urandom);
    s_in             = 1'($urandom);
    valid_in         = 1'($urandom);
    imm_in           = 1'($urandom);
    shift_operand_in = 12'($urandom);
    signed_imm_24_in = 24'($urandom);
    dest_in          = 4'($urandom);
    src1_in          = 4'($urandom);
    src2_in          = 4'($urandom);
    status_in        = 4'($urandom);
  endtask

  // Predict the result of the coming edge from the current inputs, then clock it in
  task automatic tick();
    tb_fields_t nxt;
    logic [3:0] nst;
    nst = m_status;
    if (m_f.s && m_f.valid && !freeze) nst = status_in;
    if (flush) begin
      nxt = '0;
    end else if (freeze) begin
      nxt = m_f;
    end else begin
      nxt = input_fields();
      if (!valid_in) begin
        nxt.wb = 1'b0; nxt.mr = 1'b0; nxt.mw = 1'b0; nxt.b = 1'b0; nxt.s = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    m_f      = nxt;
    m_status = nst;
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if (dut_fields() !== tb_fields_t'(0) || status_out !== 4'b0 || carry_out !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got %h st=%b, want 0", dut_fields(), status_out);
    end
    @(negedge clk);
    rst = 1'b1;
    m_f = '0;
    m_status = '0;
  endtask

  task automatic test_load();
    flush = 0; freeze = 0;
    randomize_inputs();
    exe_cmd_in = EXE_ADD; pc_in = 32'h10; val_rn_in = 32'd5; val_rm_in = 32'd7;
    wb_en_in = 1; valid_in = 1; s_in = 0;
    tick();
    vectors++;
    if (dut_fields() !== m_f || pc_out !== 32'h10 || val_rn_out !== 32'd5 ||
        val_rm_out !== 32'd7 || exe_cmd_out !== 4'b0010 || valid_out !== 1'b1 || wb_en_out !== 1'b1) begin
      miscompares++;
      $display("FAIL load_add: got %h, want %h", dut_fields(), m_f);
    end
    for (int i = 0; i < 6; i++) begin
      randomize_inputs();
      valid_in = (i % 2 == 0);
      tick();
      vectors++;
      if (dut_fields() !== m_f || status_out !== m_status) begin
        miscompares++;
        $display("FAIL load_rand%0d: got %h st=%b, want %h st=%b", i, dut_fields(), status_out, m_f, m_status);
      end
    end
  endtask

  task automatic test_flush();
    randomize_inputs();
    valid_in = 1; wb_en_in = 1; mem_w_en_in = 1; flush = 1;
    tick();
    flush = 0;
    vectors++;
    if (dut_fields() !== m_f || wb_en_out !== 1'b0 || mem_w_en_out !== 1'b0 ||
        exe_cmd_out !== 4'b0000 || valid_out !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_bubble: got %h, want %h", dut_fields(), m_f);
    end
  endtask

  task automatic test_freeze();
    tb_fields_t held;
    logic [3:0] held_st;
    randomize_inputs();
    valid_in = 1; s_in = 1;
    tick();
    held = m_f;
    held_st = m_status;
    freeze = 1;
    for (int i = 0; i < 3; i++) begin
      randomize_inputs();
      tick();
      vectors++;
      if (dut_fields() !== held || status_out !== held_st || dut_fields() !== m_f) begin
        miscompares++;
        $display("FAIL freeze_hold%0d: got %h st=%b, want %h st=%b", i, dut_fields(), status_out, held, held_st);
      end
    end
    randomize_inputs();
    valid_in = 1; wb_en_in = 1;
    flush = 1;
    tick();
    flush = 0; freeze = 0;
    vectors++;
    if (dut_fields() !== tb_fields_t'(0) || status_out !== held_st) begin
      miscompares++;
      $display("FAIL flush_freeze: got %h st=%b, want 0 st=%b", dut_fields(), status_out, held_st);
    end
  endtask

  task automatic test_status();
    randomize_inputs();
    exe_cmd_in = EXE_SUB; s_in = 1; valid_in = 1;
    tick();
    randomize_inputs();
    s_in = 0; status_in = 4'b0110;
    tick();
    vectors++;
    if (status_out !== 4'b0110 || carry_out !== 1'b1 || status_out !== m_status) begin
      miscompares++;
      $display("FAIL status_load: got %b c=%b, want 0110 c=1", status_out, carry_out);
    end
    randomize_inputs();
    status_in = 4'b1001;
    tick();
    vectors++;
    if (status_out !== 4'b0110 || carry_out !== 1'b1) begin
      miscompares++;
      $display("FAIL status_hold: got %b c=%b, want 0110 c=1", status_out, carry_out);
    end
  endtask

  task automatic test_flush_status();
    randomize_inputs();
    valid_in = 1; s_in = 1; exe_cmd_in = EXE_ADC;
    tick();
    randomize_inputs();
    status_in = 4'b1001; flush = 1;
    tick();
    flush = 0;
    vectors++;
    if (status_out !== 4'b1001 || carry_out !== 1'b0 || dut_fields() !== tb_fields_t'(0)) begin
      miscompares++;
      $display("FAIL flush_status: got st=%b f=%h, want st=1001 f=0", status_out, dut_fields());
    end
  endtask

  task automatic test_async_reset();
    randomize_inputs();
    valid_in = 1; s_in = 1; wb_en_in = 1; pc_in = 32'hDEAD_BEEF;
    tick();
    status_in = 4'b1111;
    tick();
    freeze = 1;
    randomize_inputs();
    #2;
    rst = 1'b0;
    #1;
    m_f = '0;
    m_status = '0;
    vectors++;
    if (dut_fields() !== tb_fields_t'(0) || status_out !== 4'b0 || carry_out !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: got %h st=%b, want 0", dut_fields(), status_out);
    end
    @(negedge clk);
    rst = 1'b1;
    freeze = 0;
    randomize_inputs();
    valid_in = 1;
    tick();
    vectors++;
    if (dut_fields() !== m_f || status_out !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_resume: got %h st=%b, want %h st=0", dut_fields(), status_out, m_f);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      valid_in = ($urandom_range(0, 9) < 8);
      flush    = ($urandom_range(0, 9) == 0);
      freeze   = ($urandom_range(0, 19) < 3);
      tick();
      vectors++;
      if (dut_fields() !== m_f || status_out !== m_status || carry_out !== m_status[1]) begin
        miscompares++;
        $display("FAIL random%0d: got %h st=%b, want %h st=%b", i, dut_fields(), status_out, m_f, m_status);
      end
    end
    flush = 0; freeze = 0;
  endtask

  initial begin
    m_f = '0;
    m_status = '0;
    test_reset();
    test_load();
    test_flush();
    test_freeze();
    test_status();
    test_flush_status();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/id_exe_reg.md
ID_EXE_REG -- requirements
Module: id_exe_reg

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port: rst  input  1  reset; asynchronous, active-low.
REQ-003 SHALL have ports: flush  input  1  branch taken, insert bubble; freeze  input  1  hold all state.
REQ-004 SHALL have ports: pc_in  input  32; val_rn_in  input  32; val_rm_in  input  32  decoded operands.
REQ-005 SHALL have ports: exe_cmd_in  input  4; wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in  input  1 each; valid_in  input  1.
REQ-006 SHALL have ports: imm_in  input  1; shift_operand_in  input  12; signed_imm_24_in  input  24; dest_in, src1_in, src2_in  input  4 each.
REQ-007 SHALL have a registered "_out" output of identical width for every REQ-004..006 input, plus valid_out  output  1.
REQ-008 SHALL have ports: status_in  input  4  {N,Z,C,V} from the execute ALU; status_out  output  4  registered flags; carry_out  output  1  = status_out[1], feeds ALU carry_in.

Function
REQ-009 SHALL, on a clock edge with freeze=0 and flush=0, load every "_in" field into its "_out" register (latency 1 cycle).
REQ-010 SHALL, on a clock edge with flush=1, clear wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, valid_out to 0; exe_cmd_out to 4'b0000; other fields don't-care but SHALL load 0.
REQ-011 SHALL, on a clock edge with freeze=1 and flush=0, hold every register unchanged.
REQ-012 SHALL give flush priority over freeze when both are 1.
REQ-013 SHALL, when valid_in=0 and no flush/freeze, load the fields but force wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out to 0 (bubble propagation).
REQ-014 SHALL load status_in into the status register on a clock edge iff s_out=1, valid_out=1 and freeze=0; otherwise hold.
REQ-015 SHALL update status on the same edge that flushes the pipeline register (the flag-setting instruction in execute completes; flush only affects the incoming instruction).
REQ-016 SHALL NOT update status while frozen, so a re-presented ADC/SBC sees an unchanged carry.
REQ-017 SHALL present status_out and carry_out combinationally from the status register, with no bypass from status_in.
REQ-018 SHALL be pure register plus enable logic; no arithmetic on data fields.

Reset
REQ-019 SHALL, while rst=0, asynchronously force all "_out" registers, valid_out and status_out to 0, regardless of clk, flush or freeze.
REQ-020 SHALL resume normal loading on the first rising clk edge after rst returns to 1; reset asserted mid-stall SHALL discard the held instruction.

Structure
REQ-021 SHALL take EXE_CMD encodings (MOV 0001, MVN 1001, ADD 0010, ADC 0011, SUB 0100, SBC 0101, AND 0110, ORR 0111, EOR 1000, NOP 0000) and status bit positions {N=3,Z=2,C=1,V=0} from the shared package.
REQ-022 SHALL instantiate one sub-module, status_reg (4-bit, async active-low reset, load enable), for the flags.

Verification
REQ-023 Bench SHALL drive ADD, pc_in=32'h10, val_rn_in=5, val_rm_in=7, wb_en_in=1, valid_in=1 -> next edge outputs equal inputs, valid_out=1.
REQ-024 Bench SHALL assert flush with wb_en_in=1, mem_w_en_in=1 -> next edge all control outputs 0, exe_cmd_out=0000, valid_out=0.
REQ-025 Bench SHALL assert freeze=1 for 3 cycles while changing inputs -> outputs and status_out unchanged throughout; flush+freeze together -> bubble.
REQ-026 Bench SHALL register SUB with s_in=1, then drive status_in=4'b0110 -> status_out=0110, carry_out=1 one edge later; with s_out=0 status_out holds.
REQ-027 Bench SHALL pull rst low between clock edges with valid data held -> all outputs 0 immediately, before the next clk edge.
REQ-028 Bench SHALL check flag-setting instruction in execute with flush=1 -> status_out updates while pipeline outputs bubble.
